// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM state type and mode constants for the serial add/sub block
package serial_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_lane.sv
// rtl/serial_lane.sv - one bit-serial full-adder lane with carry, sum, carry-out and overflow registers
module serial_lane
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic first_i,
  input  logic mode_i,
  input  logic last_i,
  input  logic x_i,
  input  logic y_i,
  output logic sum_o,
  output logic cout_o,
  output logic ovf_o
);

  logic carry_q, carry_d;
  logic sum_q, sum_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic cin, y_eff, s_bit, c_next;

  // Bit 0 seeds the carry with the mode so subtraction becomes x + ~y + 1.
  assign cin    = first_i ? mode_i : carry_q;
  assign y_eff  = y_i ^ (mode_i == MODE_SUB);
  assign s_bit  = x_i ^ y_eff ^ cin;
  assign c_next = (x_i & y_eff) | (x_i & cin) | (y_eff & cin);

  always_comb begin
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (en_i) begin
      carry_d = c_next;
      sum_d   = s_bit;
      if (last_i) begin
        cout_d = c_next;
        ovf_d  = cin ^ c_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      sum_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-lane LSB-first serial adder/subtractor with shared framing FSM
module serial_addsub
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             sub,
  input  logic [LANES-1:0] x,
  input  logic [LANES-1:0] y,
  output logic [LANES-1:0] sum,
  output logic             out_valid,
  output logic             out_last,
  output logic [LANES-1:0] cout,
  output logic [LANES-1:0] ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_last_q;
  logic          first, accept, last, eff_mode;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    first    = in_valid & in_first;
    accept   = first | (in_valid & (state_q == ST_RUN));
    eff_mode = first ? sub : mode_q;
    // A first beat is bit 0 and can never be the MSB since WIDTH >= 2.
    last     = accept & ~first & (cnt_q == LAST_IDX);
    if (first) begin
      state_d = ST_RUN;
      cnt_d   = CW'(1);
      mode_d  = sub;
    end else if (accept) begin
      if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_ADD;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= accept;
      out_last_q  <= last;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    serial_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (accept),
      .first_i (first),
      .mode_i  (eff_mode),
      .last_i  (last),
      .x_i     (x[l]),
      .y_i     (y[l]),
      .sum_o   (sum[l]),
      .cout_o  (cout[l]),
      .ovf_o   (ovf[l])
    );
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - randomized self-checking bench for serial_addsub against an arithmetic model
module tb_serial_addsub;

  localparam int W = 8;
  localparam int L = 4;

  typedef logic [L-1:0][W-1:0] word_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_first, sub;
  logic [L-1:0] x, y;
  logic [L-1:0] sum, cout, ovf;
  logic         out_valid, out_last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [L-1:0] exp_cout, exp_ovf;

  serial_addsub #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .sub       (sub),
    .x         (x),
    .y         (y),
    .sum       (sum),
    .out_valid (out_valid),
    .out_last  (out_last),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ovf, cout, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int au, bu, sa, sb, r, sr;
    logic c, o;
    au = int'(a);
    bu = int'(b);
    sa = a[W-1] ? au - (1 << W) : au;
    sb = b[W-1] ? bu - (1 << W) : bu;
    if (s) begin
      r  = au - bu;
      c  = (au >= bu);
      sr = sa - sb;
    end else begin
      r  = au + bu;
      c  = (r >= (1 << W));
      sr = sa + sb;
    end
    o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {o, c, r[W-1:0]};
  endfunction

  // Drive one cycle of inputs; on return the outputs reflect this beat.
  task automatic beat(input logic v, input logic f, input logic s, input logic [L-1:0] xb, input logic [L-1:0] yb);
    in_valid = v;
    in_first = f;
    sub      = s;
    x        = xb;
    y        = yb;
    @(negedge clk);
  endtask

  task automatic idle_beat(input logic v);
    beat(v, 1'b0, 1'($urandom), L'($urandom), L'($urandom));
    check("ignored_valid", 32'(out_valid), 32'(0));
  endtask

  task automatic run_word(input word_t xw, input word_t yw, input logic s,
                          input int nbits, input int stall_at, input int stall_len);
    word_t        got;
    logic [L-1:0] xb, yb;
    logic [W+1:0] m;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      for (int l = 0; l < L; l++) begin
        xb[l] = xw[l][i];
        yb[l] = yw[l][i];
      end
      beat(1'b1, i == 0, (i == 0) ? s : 1'($urandom), xb, yb);
      check("out_valid", 32'(out_valid), 32'(1));
      check("out_last", 32'(out_last), 32'(i == W - 1));
      for (int l = 0; l < L; l++) got[l][i] = sum[l];
      if (i < W - 1) begin
        check("cout_hold", 32'(cout), 32'(exp_cout));
        check("ovf_hold", 32'(ovf), 32'(exp_ovf));
      end
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          beat(1'b0, 1'($urandom), 1'($urandom), L'($urandom), L'($urandom));
          check("stall_valid", 32'(out_valid), 32'(0));
          check("stall_last", 32'(out_last), 32'(0));
        end
      end
    end
    if (nbits == W) begin
      for (int l = 0; l < L; l++) begin
        m = model(xw[l], yw[l], s);
        check($sformatf("sum_lane%0d", l), 32'(got[l]), 32'(m[W-1:0]));
        exp_cout[l] = m[W];
        exp_ovf[l]  = m[W+1];
      end
      check("cout", 32'(cout), 32'(exp_cout));
      check("ovf", 32'(ovf), 32'(exp_ovf));
    end
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int l = 0; l < L; l++) w[l] = W'($urandom);
    return w;
  endfunction

  initial begin
    word_t xw, yw;
    int    nb, st, sl;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    sub      = 1'b0;
    x        = '0;
    y        = '0;
    exp_cout = '0;
    exp_ovf  = '0;
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_last", 32'(out_last), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Beats without in_first in IDLE are dropped.
    for (int k = 0; k < 3; k++) idle_beat(1'b1);

    // Plain add, signed overflow on lane 1, unsigned carry on lane 2.
    xw = rand_word(); yw = rand_word();
    xw[0] = 8'h35; yw[0] = 8'h4A;
    xw[1] = 8'h7F; yw[1] = 8'h01;
    xw[2] = 8'hFF; yw[2] = 8'h01;
    run_word(xw, yw, 1'b0, W, -1, 0);

    // Subtract immediately after, no bubble.
    xw = rand_word(); yw = rand_word();
    xw[0] = 8'h10; yw[0] = 8'h20;
    xw[1] = 8'h80; yw[1] = 8'h01;
    run_word(xw, yw, 1'b1, W, -1, 0);
    idle_beat(1'b0);

    // Three-cycle stall after bit 3.
    xw = rand_word(); yw = rand_word();
    xw[0] = 8'h35; yw[0] = 8'h4A;
    run_word(xw, yw, 1'b0, W, 3, 3);

    // Reset after bit 4 discards the word.
    run_word(rand_word(), rand_word(), 1'b1, 5, -1, 0);
    rst = 1'b1;
    #1;
    check("midrst_sum", 32'(sum), 32'(0));
    check("midrst_valid", 32'(out_valid), 32'(0));
    check("midrst_last", 32'(out_last), 32'(0));
    check("midrst_cout", 32'(cout), 32'(0));
    check("midrst_ovf", 32'(ovf), 32'(0));
    exp_cout = '0;
    exp_ovf  = '0;
    @(negedge clk);
    rst = 1'b0;
    idle_beat(1'b1);
    xw = rand_word(); yw = rand_word();
    xw[0] = 8'h01; yw[0] = 8'h01;
    run_word(xw, yw, 1'b0, W, -1, 0);

    // in_first at bit 5 restarts cleanly.
    run_word(rand_word(), rand_word(), 1'b0, 5, -1, 0);
    xw = rand_word(); yw = rand_word();
    run_word(xw, yw, 1'b1, W, -1, 0);

    // Randomized words: aborts, stalls, idle gaps.
    for (int n = 0; n < 60; n++) begin
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W - 1)) : W;
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 2)) : -1;
      sl = int'($urandom_range(1, 3));
      run_word(rand_word(), rand_word(), 1'($urandom), nb, st, sl);
      if (nb == W && $urandom_range(0, 3) == 0) idle_beat(1'($urandom));
    end

    in_valid = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
